// File: rtl/rsa_wrap_pkg.sv
// +----------------------------------------------------------------------+
// | rsa_wrap_pkg: shared state/phase/command types and default constants  |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
`default_nettype none

package rsa_wrap_pkg;

  typedef enum logic [2:0] {
    S_POLL_RX  = 3'd0,
    S_READ_RX  = 3'd1,
    S_START    = 3'd2,
    S_CALC     = 3'd3,
    S_POLL_TX  = 3'd4,
    S_WRITE_TX = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    PH_N = 2'd0,
    PH_D = 2'd1,
    PH_A = 2'd2
  } phase_t;

  typedef enum logic [1:0] {
    CMD_STATUS = 2'd0,
    CMD_RX     = 2'd1,
    CMD_TX     = 2'd2
  } cmd_t;

  localparam int c_DEF_RX_BASE     = 0;
  localparam int c_DEF_TX_BASE     = 4;
  localparam int c_DEF_STATUS_BASE = 8;
  localparam int c_DEF_RX_OK_BIT   = 7;
  localparam int c_DEF_TX_OK_BIT   = 6;

  // Bus command a wrapper state presents once its previous transfer is accepted.
  function automatic cmd_t cmd_for_state(input state_t s);
    case (s)
      S_READ_RX:  return CMD_RX;
      S_WRITE_TX: return CMD_TX;
      default:    return CMD_STATUS;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/rsa_wrapper_param_avm_byte_port.sv
// +----------------------------------------------------------------------+
// | avm_byte_port: registered Avalon-MM master command and accept decode  |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
`default_nettype none

module avm_byte_port
  import rsa_wrap_pkg::*;
#(
  parameter int RX_BASE     = c_DEF_RX_BASE,
  parameter int TX_BASE     = c_DEF_TX_BASE,
  parameter int STATUS_BASE = c_DEF_STATUS_BASE,
  parameter int RX_OK_BIT   = c_DEF_RX_OK_BIT,
  parameter int TX_OK_BIT   = c_DEF_TX_OK_BIT
) (
  input  logic        avm_clk,
  input  logic        avm_rst,
  input  cmd_t        next_cmd,
  input  logic [7:0]  tx_byte,
  output logic [4:0]  avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  input  logic        avm_waitrequest,
  output logic        rx_ok,
  output logic        tx_ready,
  output logic        rx_valid,
  output logic [7:0]  rx_byte,
  output logic        tx_done
);

  cmd_t        r_cmd;
  logic [4:0]  r_address;
  logic        r_read;
  logic        r_write;
  logic [31:0] r_writedata;
  logic        w_accept;
  logic        w_unused;

  assign w_accept = (r_read | r_write) & ~avm_waitrequest;
  assign w_unused = ^avm_readdata;

  // The command only advances on acceptance, so a stalled transfer holds.
  always_ff @(posedge avm_clk or posedge avm_rst) begin
    if (avm_rst) begin
      r_cmd       <= CMD_STATUS;
      r_address   <= 5'(STATUS_BASE);
      r_read      <= 1'b1;
      r_write     <= 1'b0;
      r_writedata <= '0;
    end else if (w_accept) begin
      r_cmd <= next_cmd;
      case (next_cmd)
        CMD_RX: begin
          r_address   <= 5'(RX_BASE);
          r_read      <= 1'b1;
          r_write     <= 1'b0;
          r_writedata <= '0;
        end
        CMD_TX: begin
          r_address   <= 5'(TX_BASE);
          r_read      <= 1'b0;
          r_write     <= 1'b1;
          r_writedata <= {24'b0, tx_byte};
        end
        default: begin
          r_address   <= 5'(STATUS_BASE);
          r_read      <= 1'b1;
          r_write     <= 1'b0;
          r_writedata <= '0;
        end
      endcase
    end
  end

  assign avm_address   = r_address;
  assign avm_read      = r_read;
  assign avm_write     = r_write;
  assign avm_writedata = r_writedata;

  assign rx_ok    = w_accept & (r_cmd == CMD_STATUS) & avm_readdata[RX_OK_BIT];
  assign tx_ready = w_accept & (r_cmd == CMD_STATUS) & avm_readdata[TX_OK_BIT];
  assign rx_valid = w_accept & (r_cmd == CMD_RX);
  assign rx_byte  = avm_readdata[7:0];
  assign tx_done  = w_accept & (r_cmd == CMD_TX);

endmodule

`default_nettype wire

// File: rtl/rsa_wrapper_param_core.sv
// +----------------------------------------------------------------------+
// | rsa_modexp_core: bit-serial a^d mod n (left-to-right square/multiply) |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
`default_nettype none

module rsa_modexp_core #(
  parameter int KEY_BITS = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [KEY_BITS-1:0] n,
  input  logic [KEY_BITS-1:0] d,
  input  logic [KEY_BITS-1:0] a,
  output logic                finished,
  output logic [KEY_BITS-1:0] result
);

  localparam int CW = $clog2(KEY_BITS + 1);
  localparam int AW = KEY_BITS + 2;

  localparam logic [2:0] c_CS_IDLE = 3'd0;
  localparam logic [2:0] c_CS_RED  = 3'd1;
  localparam logic [2:0] c_CS_SQR  = 3'd2;
  localparam logic [2:0] c_CS_MUL  = 3'd3;
  localparam logic [2:0] c_CS_DONE = 3'd4;

  logic [2:0]          r_state;
  logic [2:0]          w_next_state;
  logic [KEY_BITS-1:0] r_acc, r_x, r_y, r_base, r_res, r_exp;
  logic [CW-1:0]       r_mcnt, r_ecnt;
  logic [AW-1:0]       w_n_ext, w_dbl, w_sum;
  logic [KEY_BITS-1:0] w_dbl_red, w_step;
  logic                w_mul_last, w_exp_last;

  // One interleaved modular-multiply step: acc = 2*acc + x_msb*y (mod n).
  always_comb begin
    w_n_ext   = {2'b00, n};
    w_dbl     = {1'b0, r_acc, 1'b0};
    w_dbl_red = (w_dbl >= w_n_ext) ? KEY_BITS'(w_dbl - w_n_ext) : KEY_BITS'(w_dbl);
    w_sum     = {2'b00, w_dbl_red} + (r_x[KEY_BITS-1] ? {2'b00, r_y} : '0);
    w_step    = (w_sum >= w_n_ext) ? KEY_BITS'(w_sum - w_n_ext) : KEY_BITS'(w_sum);
  end

  assign w_mul_last = (r_mcnt == CW'(1));
  assign w_exp_last = (r_ecnt == CW'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= c_CS_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_CS_IDLE: if (start) w_next_state = c_CS_RED;
      c_CS_RED:  if (w_mul_last) w_next_state = c_CS_SQR;
      c_CS_SQR:  if (w_mul_last)
                   w_next_state = r_exp[KEY_BITS-1] ? c_CS_MUL : (w_exp_last ? c_CS_DONE : c_CS_SQR);
      c_CS_MUL:  if (w_mul_last) w_next_state = w_exp_last ? c_CS_DONE : c_CS_SQR;
      c_CS_DONE: w_next_state = c_CS_IDLE;
      default:   w_next_state = c_CS_IDLE;
    endcase
  end

  always_comb begin
    finished = (r_state == c_CS_DONE);
  end

  assign result = r_res;

  // The reduce pass (a*1 mod n) lets the ciphertext exceed the modulus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc  <= '0;
      r_x    <= '0;
      r_y    <= '0;
      r_base <= '0;
      r_res  <= '0;
      r_exp  <= '0;
      r_mcnt <= '0;
      r_ecnt <= '0;
    end else begin
      case (r_state)
        c_CS_IDLE: if (start) begin
          r_x    <= a;
          r_y    <= KEY_BITS'(1);
          r_acc  <= '0;
          r_mcnt <= CW'(KEY_BITS);
          r_exp  <= d;
          r_ecnt <= CW'(KEY_BITS);
          r_res  <= KEY_BITS'(1);
        end
        c_CS_RED, c_CS_SQR, c_CS_MUL: begin
          r_acc  <= w_step;
          r_x    <= r_x << 1;
          r_mcnt <= r_mcnt - CW'(1);
          if (w_mul_last) begin
            r_acc  <= '0;
            r_mcnt <= CW'(KEY_BITS);
            if (r_state == c_CS_RED) begin
              r_base <= w_step;
              r_x    <= r_res;
              r_y    <= r_res;
            end else if (r_state == c_CS_SQR && r_exp[KEY_BITS-1]) begin
              r_res <= w_step;
              r_x   <= w_step;
              r_y   <= r_base;
            end else begin
              r_res  <= w_step;
              r_x    <= w_step;
              r_y    <= w_step;
              r_exp  <= r_exp << 1;
              r_ecnt <= r_ecnt - CW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/rsa_wrapper_param.sv
// +----------------------------------------------------------------------+
// | rsa_wrapper_param: UART-to-modexp Avalon master, parametrised key    |
// | Option: RSA_WRAP_KEEP_KEY_EN keeps n and d across blocks.            |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
`default_nettype none

module rsa_wrapper_param
  import rsa_wrap_pkg::*;
#(
  parameter int KEY_BITS    = 256,
  parameter int OUT_BYTES   = KEY_BITS / 8 - 1,
  parameter int RX_BASE     = c_DEF_RX_BASE,
  parameter int TX_BASE     = c_DEF_TX_BASE,
  parameter int STATUS_BASE = c_DEF_STATUS_BASE,
  parameter int RX_OK_BIT   = c_DEF_RX_OK_BIT,
  parameter int TX_OK_BIT   = c_DEF_TX_OK_BIT
) (
  input  logic        avm_clk,
  input  logic        avm_rst,
  output logic [4:0]  avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  input  logic        avm_waitrequest,
  output logic        o_busy,
  output logic [15:0] o_blocks_done
);

  localparam int KEY_BYTES = KEY_BITS / 8;
  localparam int CNT_W     = $clog2(KEY_BYTES + 1);
  localparam logic [CNT_W-1:0] c_LAST_RX = CNT_W'(KEY_BYTES - 1);
  localparam logic [CNT_W-1:0] c_LAST_TX = CNT_W'(OUT_BYTES - 1);

  state_t              r_state, w_next_state;
  phase_t              r_phase;
  logic [CNT_W-1:0]    r_cnt;
  logic [KEY_BITS-1:0] r_n, r_d, r_a, r_result;
  logic [15:0]         r_blocks_done;
  logic                w_rx_ok, w_tx_ready, w_rx_valid, w_tx_done;
  logic [7:0]          w_rx_byte;
  logic                w_start, w_core_finished;
  logic [KEY_BITS-1:0] w_core_result;

  avm_byte_port #(
    .RX_BASE     (RX_BASE),
    .TX_BASE     (TX_BASE),
    .STATUS_BASE (STATUS_BASE),
    .RX_OK_BIT   (RX_OK_BIT),
    .TX_OK_BIT   (TX_OK_BIT)
  ) u_port (
    .avm_clk         (avm_clk),
    .avm_rst         (avm_rst),
    .next_cmd        (cmd_for_state(w_next_state)),
    .tx_byte         (r_result[8*OUT_BYTES-1 -: 8]),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_readdata    (avm_readdata),
    .avm_write       (avm_write),
    .avm_writedata   (avm_writedata),
    .avm_waitrequest (avm_waitrequest),
    .rx_ok           (w_rx_ok),
    .tx_ready        (w_tx_ready),
    .rx_valid        (w_rx_valid),
    .rx_byte         (w_rx_byte),
    .tx_done         (w_tx_done)
  );

  rsa_modexp_core #(
    .KEY_BITS (KEY_BITS)
  ) u_core (
    .clk      (avm_clk),
    .rst      (avm_rst),
    .start    (w_start),
    .n        (r_n),
    .d        (r_d),
    .a        (r_a),
    .finished (w_core_finished),
    .result   (w_core_result)
  );

  always_ff @(posedge avm_clk or posedge avm_rst) begin
    if (avm_rst) r_state <= S_POLL_RX;
    else         r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_POLL_RX:  if (w_rx_ok) w_next_state = S_READ_RX;
      S_READ_RX:  if (w_rx_valid)
                    w_next_state = (r_phase == PH_A && r_cnt == c_LAST_RX) ? S_START : S_POLL_RX;
      S_START:    w_next_state = S_CALC;
      S_CALC:     if (w_core_finished) w_next_state = S_POLL_TX;
      S_POLL_TX:  if (w_tx_ready) w_next_state = S_WRITE_TX;
      S_WRITE_TX: if (w_tx_done)
                    w_next_state = (r_cnt == c_LAST_TX) ? S_POLL_RX : S_POLL_TX;
      default:    w_next_state = S_POLL_RX;
    endcase
  end

  always_comb begin
    w_start = (r_state == S_START);
    o_busy  = (r_state == S_START) || (r_state == S_CALC) ||
              (r_state == S_POLL_TX) || (r_state == S_WRITE_TX);
  end

  assign o_blocks_done = r_blocks_done;

  always_ff @(posedge avm_clk or posedge avm_rst) begin
    if (avm_rst) begin
      r_phase       <= PH_N;
      r_cnt         <= '0;
      r_n           <= '0;
      r_d           <= '0;
      r_a           <= '0;
      r_result      <= '0;
      r_blocks_done <= '0;
    end else begin
      case (r_state)
        S_READ_RX: if (w_rx_valid) begin
          case (r_phase)
            PH_N:    r_n <= {r_n[KEY_BITS-9:0], w_rx_byte};
            PH_D:    r_d <= {r_d[KEY_BITS-9:0], w_rx_byte};
            default: r_a <= {r_a[KEY_BITS-9:0], w_rx_byte};
          endcase
          if (r_cnt == c_LAST_RX) begin
            r_cnt <= '0;
            case (r_phase)
              PH_N:    r_phase <= PH_D;
              default: r_phase <= PH_A;
            endcase
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_CALC: if (w_core_finished) r_result <= w_core_result;
        S_WRITE_TX: if (w_tx_done) begin
          // Rotating the whole word brings the next-lower byte under the tx tap.
          r_result <= {r_result[KEY_BITS-9:0], r_result[KEY_BITS-1 -: 8]};
          if (r_cnt == c_LAST_TX) begin
            r_cnt         <= '0;
            r_blocks_done <= r_blocks_done + 16'd1;
`ifdef RSA_WRAP_KEEP_KEY_EN
            r_phase  <= PH_A;
            r_a      <= '0;
            r_result <= '0;
`else
            r_phase  <= PH_N;
            r_n      <= '0;
            r_d      <= '0;
            r_a      <= '0;
            r_result <= '0;
`endif
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rsa_wrapper_param.sv
// +----------------------------------------------------------------------+
// | tb_rsa_wrapper_param: UART slave model plus modexp scoreboard        |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_rsa_wrapper_param;

  localparam int KB = 32;
  localparam int OB = 3;
  localparam int BUDGET = 20000;

  logic        avm_clk = 1'b0;
  logic        avm_rst;
  logic [4:0]  avm_address;
  logic        avm_read;
  logic [31:0] avm_readdata;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic        avm_waitrequest;
  logic        o_busy;
  logic [15:0] o_blocks_done;

  rsa_wrapper_param #(.KEY_BITS(KB), .OUT_BYTES(OB)) dut (
    .avm_clk         (avm_clk),
    .avm_rst         (avm_rst),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_readdata    (avm_readdata),
    .avm_write       (avm_write),
    .avm_writedata   (avm_writedata),
    .avm_waitrequest (avm_waitrequest),
    .o_busy          (o_busy),
    .o_blocks_done   (o_blocks_done)
  );

  always #5 avm_clk = ~avm_clk;

  int total = 0;
  int bad   = 0;
  logic [7:0] rx_q[$];
  logic [7:0] exp_tx[$];
  int stall_pct = 0, rxok_pct = 100, txok_pct = 100;
  int exp_blocks = 0;
  bit key_loaded = 0;
  logic [31:0] cur_n, cur_d;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Slave decides the coming edge's outcome on the falling edge.
  logic        prev_stall = 1'b0;
  logic [38:0] prev_cmd;
  always @(negedge avm_clk) begin
    avm_readdata = 32'h0;
    if (avm_rst) begin
      avm_waitrequest = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        check("stall_hold", {avm_address, avm_read, avm_write, avm_writedata}, prev_cmd);
      avm_waitrequest = ($urandom_range(99) < stall_pct);
      if (avm_read && avm_address == 5'd8)
        avm_readdata = {24'h0,
                        (rx_q.size() != 0) && ($urandom_range(99) < rxok_pct),
                        ($urandom_range(99) < txok_pct),
                        6'($urandom)};
      else if (avm_read && avm_address == 5'd0 && rx_q.size() != 0)
        avm_readdata = {24'h0, rx_q[0]};
      if (!avm_waitrequest) begin
        if (avm_read && avm_address == 5'd0) begin
          total++;
          if (rx_q.size() == 0) begin
            bad++;
            $display("FAIL rx_underflow: got RX read with empty uart, expected none");
          end else void'(rx_q.pop_front());
        end
        if (avm_write) begin
          if (exp_tx.size() == 0) begin
            total++;
            bad++;
            $display("FAIL tx_unexpected: got write %0h, expected no write", avm_writedata);
          end else begin
            check("tx_byte", {avm_address, avm_writedata}, {5'd4, 24'h0, exp_tx.pop_front()});
          end
        end
      end
      prev_stall = avm_waitrequest && (avm_read || avm_write);
      prev_cmd   = {avm_address, avm_read, avm_write, avm_writedata};
    end
  end

  function automatic logic [31:0] ref_modexp(input logic [31:0] n, input logic [31:0] d,
                                              input logic [31:0] a);
    longint unsigned r = 64'd1 % n;
    longint unsigned b = a % n;
    for (int i = 0; i < 32; i++) begin
      if (d[i]) r = (r * b) % n;
      b = (b * b) % n;
    end
    return r[31:0];
  endfunction

  task automatic push_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) rx_q.push_back(w[8*i +: 8]);
  endtask

  task automatic send_block(input logic [31:0] n, input logic [31:0] d, input logic [31:0] a);
    logic [31:0] r;
`ifdef RSA_WRAP_KEEP_KEY_EN
    if (key_loaded) begin
      n = cur_n;
      d = cur_d;
    end else begin
      push_word(n);
      push_word(d);
    end
`else
    push_word(n);
    push_word(d);
`endif
    cur_n = n;
    cur_d = d;
    push_word(a);
    r = ref_modexp(n, d, a);
    for (int i = OB - 1; i >= 0; i--) exp_tx.push_back(r[8*i +: 8]);
    exp_blocks++;
  endtask

  task automatic wait_done(input string tag);
    int cyc = 0;
    while ((exp_tx.size() != 0 || rx_q.size() != 0) && cyc < BUDGET) begin
      @(posedge avm_clk);
      cyc++;
    end
    total++;
    if (cyc >= BUDGET) begin
      bad++;
      $display("FAIL %s_timeout: got %0d tx bytes pending, expected 0", tag, exp_tx.size());
    end
    repeat (3) @(posedge avm_clk);
    #1;
    check({tag, "_blocks"}, 64'(o_blocks_done), 64'(exp_blocks));
    check({tag, "_busy"}, 64'(o_busy), 64'(0));
    key_loaded = 1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_addr"},  64'(avm_address), 64'(8));
    check({tag, "_read"},  64'(avm_read), 64'(1));
    check({tag, "_write"}, 64'(avm_write), 64'(0));
    check({tag, "_wdata"}, 64'(avm_writedata), 64'(0));
    check({tag, "_busy"},  64'(o_busy), 64'(0));
    check({tag, "_blocks"}, 64'(o_blocks_done), 64'(0));
  endtask

  // Called just after a rising edge.
  task automatic do_reset(input string tag);
    #2 avm_rst = 1'b1;
    #1 check_reset_vals(tag);
    rx_q.delete();
    exp_tx.delete();
    exp_blocks = 0;
    key_loaded = 0;
    repeat (3) @(posedge avm_clk);
    #2 avm_rst = 1'b0;
  endtask

  initial begin
    int cyc;
    avm_rst = 1'b1;
    repeat (2) @(posedge avm_clk);
    #1 check_reset_vals("por");
    #1 avm_rst = 1'b0;

    // Directed key: 2^5 mod 13 = 6
    send_block(32'h0000000D, 32'h00000005, 32'h00000002);
    wait_done("basic");

`ifdef RSA_WRAP_KEEP_KEY_EN
    // Retained key: 3^5 mod 13 = 9
    send_block(32'h0000000D, 32'h00000005, 32'h00000003);
    wait_done("keep");
`else
    push_word(32'h00000003);
    repeat (300) @(posedge avm_clk);
    #1;
    check("reload_rxq", 64'(rx_q.size()), 64'(0));
    check("reload_busy", 64'(o_busy), 64'(0));
    check("reload_blocks", 64'(o_blocks_done), 64'(exp_blocks));
`endif
    @(posedge avm_clk);
    do_reset("rst1");

    stall_pct = 60; rxok_pct = 20; txok_pct = 100;
    send_block(32'h0000000D, 32'h00000005, 32'h00000002);
    wait_done("stall");

    stall_pct = 0; rxok_pct = 100; txok_pct = 10;
    send_block(32'h0000000D, 32'h00000005, 32'h00000002);
    wait_done("txok");

    // Reset while the second result byte is on the bus
    txok_pct = 100;
    send_block(32'h0000000D, 32'h00000005, 32'h00000002);
    cyc = 0;
    while (exp_tx.size() > OB - 1 && cyc < BUDGET) begin
      @(posedge avm_clk);
      cyc++;
    end
    total++;
    if (cyc >= BUDGET) begin
      bad++;
      $display("FAIL midrst_timeout: got %0d tx bytes pending, expected %0d", exp_tx.size(), OB - 1);
    end
    @(posedge avm_clk);
    do_reset("midrst");
    send_block(32'h0000000D, 32'h00000005, 32'h00000002);
    wait_done("reload");

    for (int k = 0; k < 5; k++) begin
      stall_pct = $urandom_range(50);
      rxok_pct  = $urandom_range(100, 30);
      txok_pct  = $urandom_range(100, 20);
      send_block($urandom | 32'h3, $urandom, $urandom);
      wait_done("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
